// File: rtl/csa_pkg.sv
// Shared types and constants for the sequential carry-select adder.
// The state enum and slice width are common to the sequencer and its helpers.
package csa_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } csa_seq_state_t;

    // Number of slice cycles needed to cover an operand of the given width.
    function automatic int slice_count(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/csa8.sv
// 8-bit carry-select adder slice.
// The low nibble ripples; the high nibble is precomputed for both carries and selected.
module csa8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [4:0] lo;
    logic [4:0] hi_c0;
    logic [4:0] hi_c1;

    always_comb begin
        lo    = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
        hi_c0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        hi_c1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
    end

    // The low nibble's carry picks which precomputed high half is used.
    always_comb begin
        sum[3:0] = lo[3:0];
        if (lo[4]) begin
            sum[7:4] = hi_c1[3:0];
            cout     = hi_c1[4];
        end else begin
            sum[7:4] = hi_c0[3:0];
            cout     = hi_c0[4];
        end
    end

endmodule

// File: rtl/csa_seq_adder.sv
// Sequencer that adds WIDTH-bit operands through one shared csa8 slice, LSB slice first,
// with valid/ready handshakes on both the operand and the result side.
module csa_seq_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = slice_count(WIDTH);
    localparam int IDX_W  = $clog2(NSLICE) + 1;

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
        $error("csa_seq_adder: WIDTH must be a multiple of 8 and at least 8");
    end

    csa_seq_state_t state;
    csa_seq_state_t next_state;

    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   sum_shift;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               a_msb_q;
    logic               b_msb_q;
    logic               cout_q;
    logic               ovf_q;
    logic               last_slice;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    csa8 u_csa8 (
        .a    (a_sh[SLICE_W-1:0]),
        .b    (b_sh[SLICE_W-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

    // Each new slice byte enters at the MSB end, so after NSLICE cycles the bytes are in order.
    if (WIDTH == SLICE_W) begin : g_single_slice
        assign sum_shift = slice_sum;
    end else begin : g_multi_slice
        assign sum_shift = {slice_sum, sum_q[WIDTH-1:SLICE_W]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start_valid) next_state = RUN;
            RUN:  if (last_slice) next_state = DONE;
            DONE: if (res_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        unique case (state)
            IDLE: start_ready = 1'b1;
            RUN:  busy = 1'b1;
            DONE: begin
                res_valid = 1'b1;
                busy      = 1'b1;
            end
            default: start_ready = 1'b0;
        endcase
    end

    // Datapath: operand capture in IDLE, one slice per cycle in RUN, results held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> SLICE_W;
                    b_sh    <= b_sh >> SLICE_W;
                    sum_q   <= sum_shift;
                    carry_q <= slice_cout;
                    if (last_slice) begin
                        cout_q <= slice_cout;
                        ovf_q  <= (a_msb_q == b_msb_q) && (slice_sum[SLICE_W-1] != a_msb_q);
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_csa_seq_adder.sv
// Scoreboard bench for csa_seq_adder at WIDTH=32 and WIDTH=8, checked against a
// plain-arithmetic reference of a + b + cin.
module tb_csa_seq_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          compared;
    int          mismatched;

    logic        start_valid32, start_ready32, cin32, res_valid32, res_ready32;
    logic        cout32, ovf32, busy32;
    logic [31:0] a32, b32, sum32;

    logic        start_valid8, start_ready8, cin8, res_valid8, res_ready8;
    logic        cout8, ovf8, busy8;
    logic [7:0]  a8, b8, sum8;

    exp_t        q32[$];
    exp_t        q8[$];
    logic        prev32, prev8;
    logic        rst_done, rnd32_on, done8;

    csa_seq_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start_valid(start_valid32), .start_ready(start_ready32),
        .a(a32), .b(b32), .cin(cin32), .res_valid(res_valid32), .res_ready(res_ready32),
        .sum(sum32), .cout(cout32), .ovf(ovf32), .busy(busy32)
    );

    csa_seq_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_valid(start_valid8), .start_ready(start_ready8),
        .a(a8), .b(b8), .cin(cin8), .res_valid(res_valid8), .res_ready(res_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full-precision integer addition, then read carry and sign bits off the result.
    function automatic exp_t refModel(input int w, input logic [31:0] av, input logic [31:0] bv,
                                      input logic cv, input int acc);
        exp_t        e;
        logic [32:0] full;
        logic [31:0] mask;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        full   = {1'b0, av & mask} + {1'b0, bv & mask} + {32'd0, cv};
        e.sum  = full[31:0] & mask;
        e.cout = full[w];
        e.ovf  = (av[w-1] == bv[w-1]) && (e.sum[w-1] != av[w-1]);
        e.acc  = acc;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Hold operands until an accepting edge, then drop start_valid.
    task automatic applyStimulus(input int unit, input logic [31:0] av, input logic [31:0] bv,
                                 input logic cv);
        logic ok;
        ok = 1'b0;
        if (unit == 0) begin
            a32 = av; b32 = bv; cin32 = cv; start_valid32 = 1'b1;
        end else begin
            a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv; start_valid8 = 1'b1;
        end
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = (unit == 0) ? (start_ready32 && !rst) : (start_ready8 && !rst);
        end
        if (!ok) checkOutput(unit == 0 ? "accept timeout w32" : "accept timeout w8", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (unit == 0) start_valid32 = 1'b0;
        else start_valid8 = 1'b0;
    endtask

    task automatic waitResult(input string tag, input logic [31:0] es, input logic ec,
                              input logic eo);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = res_valid32;
        end
        if (!seen) begin
            checkOutput({tag, " timeout"}, 64'd0, 64'd1);
        end else begin
            checkOutput({tag, " sum"}, 64'(sum32), 64'(es));
            checkOutput({tag, " cout"}, 64'(cout32), 64'(ec));
            checkOutput({tag, " ovf"}, 64'(ovf32), 64'(eo));
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 32-bit instance: latency on rise, contents every DONE cycle, pop on handshake.
    always @(negedge clk) begin
        if (rst) begin
            q32.delete();
        end else begin
            if (res_valid32) begin
                if (q32.size() == 0) begin
                    checkOutput("w32 unexpected result", 64'd1, 64'd0);
                end else begin
                    if (!prev32) checkOutput("w32 latency", 64'(cyc - q32[0].acc), 64'd4);
                    checkOutput("w32 sum", 64'(sum32), 64'(q32[0].sum));
                    checkOutput("w32 cout", 64'(cout32), 64'(q32[0].cout));
                    checkOutput("w32 ovf", 64'(ovf32), 64'(q32[0].ovf));
                    checkOutput("w32 start_ready in DONE", 64'(start_ready32), 64'd0);
                    if (res_ready32) void'(q32.pop_front());
                end
            end
            if (start_valid32 && start_ready32)
                q32.push_back(refModel(32, a32, b32, cin32, cyc + 1));
        end
        prev32 = res_valid32 && !rst;
    end

    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
        end else begin
            if (res_valid8) begin
                if (q8.size() == 0) begin
                    checkOutput("w8 unexpected result", 64'd1, 64'd0);
                end else begin
                    if (!prev8) checkOutput("w8 latency", 64'(cyc - q8[0].acc), 64'd1);
                    checkOutput("w8 sum", 64'(sum8), 64'(q8[0].sum));
                    checkOutput("w8 cout", 64'(cout8), 64'(q8[0].cout));
                    checkOutput("w8 ovf", 64'(ovf8), 64'(q8[0].ovf));
                    if (res_ready8) void'(q8.pop_front());
                end
            end
            if (start_valid8 && start_ready8)
                q8.push_back(refModel(8, {24'd0, a8}, {24'd0, b8}, cin8, cyc + 1));
        end
        prev8 = res_valid8 && !rst;
    end

    initial begin
        wait (rnd32_on);
        while (rnd32_on) begin
            @(posedge clk);
            #1;
            res_ready32 = 1'($urandom_range(0, 1));
        end
        res_ready32 = 1'b1;
    end

    initial begin
        wait (rst_done);
        while (!done8) begin
            @(posedge clk);
            #1;
            res_ready8 = 1'($urandom_range(0, 1));
        end
        res_ready8 = 1'b1;
    end

    initial begin
        wait (rst_done);
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(1, randOperand(), randOperand(), 1'($urandom_range(0, 1)));
        end
        done8 = 1'b1;
    end

    initial begin
        cyc = 0; compared = 0; mismatched = 0;
        prev32 = 1'b0; prev8 = 1'b0;
        rst_done = 1'b0; rnd32_on = 1'b0; done8 = 1'b0;
        rst = 1'b1;
        start_valid32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; res_ready32 = 1'b1;
        start_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; res_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset start_ready", 64'(start_ready32), 64'd1);
        checkOutput("reset res_valid", 64'(res_valid32), 64'd0);
        checkOutput("reset busy", 64'(busy32), 64'd0);
        checkOutput("reset sum", 64'(sum32), 64'd0);
        checkOutput("reset cout", 64'(cout32), 64'd0);
        checkOutput("reset ovf", 64'(ovf32), 64'd0);
        @(posedge clk);
        #1;
        rst_done = 1'b1;

        applyStimulus(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        waitResult("t1", 32'h0000_0100, 1'b0, 1'b0);
        applyStimulus(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        waitResult("t2", 32'h0000_0000, 1'b1, 1'b0);
        applyStimulus(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        waitResult("t3a", 32'h8000_0000, 1'b0, 1'b1);
        applyStimulus(0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        waitResult("t3b", 32'h0000_0000, 1'b1, 1'b1);

        // Backpressure with new operands waiting; the held result must not move.
        res_ready32 = 1'b0;
        applyStimulus(0, 32'hDEAD_BEEF, 32'h0123_4567, 1'b1);
        waitResult("t4a", 32'hDFD1_0457, 1'b0, 1'b0);
        a32 = 32'h0F0F_0F0F; b32 = 32'h70F0_F0F0; cin32 = 1'b0; start_valid32 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("t4 start_ready held", 64'(start_ready32), 64'd0);
            checkOutput("t4 res_valid held", 64'(res_valid32), 64'd1);
        end
        @(posedge clk);
        #1;
        res_ready32 = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t4 idle start_ready", 64'(start_ready32), 64'd1);
        checkOutput("t4 idle res_valid", 64'(res_valid32), 64'd0);
        @(posedge clk);
        #1;
        start_valid32 = 1'b0;
        @(negedge clk);
        checkOutput("t4 accepted busy", 64'(busy32), 64'd1);
        waitResult("t4b", 32'h7FFF_FFFF, 1'b0, 1'b0);

        // Abort mid-operation with a one-cycle reset.
        applyStimulus(0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5 start_ready", 64'(start_ready32), 64'd1);
        checkOutput("t5 res_valid", 64'(res_valid32), 64'd0);
        checkOutput("t5 busy", 64'(busy32), 64'd0);
        checkOutput("t5 sum", 64'(sum32), 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
        waitResult("t5b", 32'h2345_6789, 1'b0, 1'b0);

        rnd32_on = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(0, randOperand(), randOperand(), 1'($urandom_range(0, 1)));
        end
        rnd32_on = 1'b0;

        for (int i = 0; i < 40000 && !done8; i++) @(posedge clk);
        checkOutput("w8 stream finished", 64'(done8), 64'd1);
        for (int i = 0; i < 200 && (q32.size() != 0 || q8.size() != 0); i++) @(negedge clk);
        checkOutput("w32 queue drained", 64'(q32.size()), 64'd0);
        checkOutput("w8 queue drained", 64'(q8.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
